// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared helpers for the shared-adder arbiter slice.
//   id_width       - requester tag width for a given requester count
//   last_grant_rst - reset value of the round-robin pointer (requester 0 wins first)
//   slice_lo       - low bit of requester idx inside a packed operand bus
package adder_share_pkg;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned last_grant_rst(input int unsigned num_req);
    return num_req - 1;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/adder.sv
// adder: N-bit Kogge-Stone adder, no carry in.
//   A, B - operands
//   Sum  - (A + B) mod 2^N
//   Cout - carry out of bit N-1
module adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N-1:0] p0;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] gn;
  logic [N-1:0] pn;

  // Prefix tree: after the loop g[i] is the carry out of bit i.
  always_comb begin
    p0 = A ^ B;
    g  = A & B;
    p  = p0;
    gn = '0;
    pn = '0;
    for (int unsigned d = 1; d < N; d = d * 2) begin
      gn = g;
      pn = p;
      for (int unsigned i = d; i < N; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
  end

  assign Sum  = p0 ^ (g << 1);
  assign Cout = g[N-1];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req        - request vector
//   last_grant - index granted most recently; search starts just after it
//   en         - when low, grant is all zero (grant_idx still reports the pick)
//   grant      - one-hot grant
//   grant_idx  - index of the picked requester
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     grant_idx
);

  logic           found;
  logic [IdW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IdW'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one adder among NUM_REQ clients.
// Two-stage pipeline: s1 holds the accepted operands, stage 2 holds the
// registered sum as a valid/ready response tagged with the requester index.
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        - packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready - response handshake
//   rsp_id/sum/cout     - response payload
//   busy                - any stage occupied
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  localparam logic [ID_W-1:0] LastGrantRst = ID_W'(last_grant_rst(NUM_REQ));

  logic            s1_valid;
  logic [N-1:0]    s1_a;
  logic [N-1:0]    s1_b;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] last_grant;

  logic            s2_load;
  logic            s1_adv;
  logic            accept;
  logic            fire;
  logic [ID_W-1:0] grant_idx;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic [N-1:0]    sum;
  logic            cout;

  assign s2_load = !rsp_valid | rsp_ready;
  assign s1_adv  = s1_valid & s2_load;
  assign accept  = !s1_valid | s1_adv;

  // Gating with rst keeps req_ready low for the whole reset, not just after the edge.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (accept & ~rst),
    .grant      (req_ready),
    .grant_idx  (grant_idx)
  );

  assign fire  = |req_ready;
  assign sel_a = req_a[slice_lo(32'(grant_idx), N) +: N];
  assign sel_b = req_b[slice_lo(32'(grant_idx), N) +: N];

  adder #(
    .N (N)
  ) u_adder (
    .A    (s1_a),
    .B    (s1_b),
    .Sum  (sum),
    .Cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      last_grant <= LastGrantRst;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      // s1 refills on accept; drains to empty when it advances with no new request.
      if (accept) s1_valid <= fire;
      if (fire) begin
        s1_a       <= sel_a;
        s1_b       <= sel_b;
        s1_id      <= grant_idx;
        last_grant <= grant_idx;
      end
      if (s2_load) rsp_valid <= s1_valid;
      if (s1_adv) begin
        rsp_sum  <= sum;
        rsp_cout <= cout;
        rsp_id   <= s1_id;
      end
    end
  end

  assign busy = s1_valid | rsp_valid;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one instance of the team's Kogge-Stone `adder` module (ports A, B, Sum, Cout; parameter N) among NUM_REQ requesters.
- Round-robin arbitration picks one request per cycle. Operands are registered and the adder result is registered, giving a 2-stage pipeline.
- Output is a valid/ready response tagged with the requester ID.
- Sits between client blocks and the shared adder datapath.

Parameters:
- N, 4, operand/sum width passed to `adder`.
- NUM_REQ, 4, number of requesters (>=2).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*N  operand A; requester i occupies bits [i*N +: N].
- req_b  in  NUM_REQ*N  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  ID_W  requester index of the result.
- rsp_sum  out  N  sum[N-1:0].
- rsp_cout  out  1  carry out.
- busy  out  1  s1_valid | rsp_valid.

Behaviour:
- Reset: clk and rst are the only clock/reset. rst is asynchronous and active-high. While rst is high, immediately:
  - s1_valid, rsp_valid, busy = 0.
  - req_ready = 0.
  - rsp_id, rsp_sum, rsp_cout = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- Pipeline control:
  - s2_load = !rsp_valid | rsp_ready.
  - s1_adv = s1_valid & s2_load.
  - accept = !s1_valid | s1_adv.
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping; the first set bit is grant.
  - req_ready[grant] = accept & |req_valid. All other bits are 0.
  - req_ready depends on req_valid. Requesters must not make valid depend on ready.
- Handshake: requester i is accepted when req_valid[i] & req_ready[i]. On that edge:
  - Latch its A/B into s1_a/s1_b and its index into s1_id.
  - Set s1_valid = 1 and last_grant = i.
- last_grant changes only on an accepted handshake. Idle cycles do not rotate priority.
- Stage 2: `adder` is fed from s1_a/s1_b. On s1_adv:
  - rsp_sum = Sum, rsp_cout = Cout, rsp_id = s1_id, rsp_valid = 1.
- If s2_load is high and s1 is empty, rsp_valid clears on that edge.
- Latency: accept at edge t means rsp_valid is high after edge t+1, i.e. the response is visible 2 cycles after the accept cycle.
- Throughput is 1 result per cycle while rsp_ready is held high.
- Backpressure: while rsp_valid & !rsp_ready:
  - rsp_* hold stable.
  - s1 holds.
  - If s1 is full, req_ready is all 0.
- Simultaneous events: when rsp_ready, s1 full and a new request all occur in one cycle, all three moves happen on the same edge with no bubble.
- Ordering: responses leave in accept order. No operand or result is ever dropped or duplicated outside reset.
- Arithmetic: {rsp_cout, rsp_sum} = A + B, width N+1, wrapping modulo 2^N with the carry in rsp_cout.
- Reset mid-operation: in-flight s1 and s2 contents are discarded. No response is produced for them.
- State machine: implicit occupancy FSM {EMPTY, S1, S2, S1S2} derived from s1_valid and rsp_valid. No extra encoded state.

Decomposition:
- Shared package/include `adder_share_pkg`:
  - ID_W computation function (clog2).
  - Reset value constant for last_grant.
  - Operand slice helper.
- Sub-module `rr_arbiter` (params NUM_REQ):
  - Inputs: req, last_grant, en.
  - Outputs: one-hot grant and grant_idx.
  - Purely combinational. The last_grant register stays in the parent.
- The existing `adder` is instantiated unmodified.

Test Plan (N=4, NUM_REQ=4):
1. Reset then single request: req_valid=0001, A0=1111, B0=0001, rsp_ready=1 -> req_ready=0001 in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=0000, rsp_cout=1.
2. All valid at once: req_valid=1111, operands A_i=i, B_i=0011, rsp_ready=1 -> grants 0,1,2,3 on consecutive cycles. Responses back-to-back: sums 0011, 0100, 0101, 0110 with matching IDs, cout=0.
3. Fairness: req0 and req2 held valid continuously -> grant sequence 0,2,0,2,...; req1 and req3 never granted.
4. Backpressure: stream from req1, rsp_ready=0 for 5 cycles:
   - rsp_* stable.
   - After one more accept, req_ready=0000.
   - Release rsp_ready -> the held result, then the s1 result, then new accepts; no loss, order preserved.
5. Vectors through req3: 1100+0011 -> 1111/0; 1110+0001 -> 1111/0; 1000+1000 -> 0000/1; 1010+1101 -> 0111/1; 0000+0000 -> 0000/0.
6. Async reset mid-flight: with s1 and rsp full, assert rst between edges -> rsp_valid and busy drop immediately; after release, req_valid=1000|0001 grants requester 0 first and no stale response appears.
